stream_demux: RTL and testbench
===============================

// Module: stream_demux
// PURPOSE
//   Parametrised 1-to-N stream demultiplexer with valid/ready handshake and one
//   registered output slot per channel. Successor to the combinational 4-way demux.
//   Adds three routing modes: select, broadcast and round-robin, plus an error pulse.
//   Sits between a single producer and N independent consumers in datapath examples.
// PARAMETERS
//   N_CH    4  number of output channels, >= 2; need not be a power of 2
//   DATA_W  8  payload width in bits
//   SEL_W   localparam = $clog2(N_CH); width of in_sel and rr_ptr
// PORTS
//   clk        in   1            rising-edge clock
//   rst        in   1            asynchronous, active-high reset
//   mode       in   2            00 SEL, 01 BCAST, 10 RR, 11 reserved
//   in_valid   in   1            producer beat valid
//   in_ready   out  1            producer beat accepted when in_valid & in_ready
//   in_data    in   DATA_W       producer payload
//   in_sel     in   SEL_W        target channel in SEL mode
//   out_valid  out  N_CH         per-channel slot holds a beat
//   out_ready  in   N_CH         per-channel consumer ready
//   out_data   out  N_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W]
//   rr_ptr     out  SEL_W        next round-robin target (status)
//   err        out  1            one-cycle pulse: beat dropped (bad sel or mode 11)
// BEHAVIOUR
//   Reset (async, while rst=1): out_valid=0, out_data=0, rr_ptr=0, err=0.
//   Slot free: free[i] = ~out_valid[i] | out_ready[i]; a draining slot refills in
//     the same cycle, so each channel sustains 1 beat/cycle.
//   Target mask tm (combinational):
//     SEL: onehot(in_sel); all-zero if in_sel >= N_CH.
//     BCAST: all ones.
//     RR: onehot(rr_ptr).
//     11: all-zero.
//   in_ready:
//     tm==0 -> 1, so an invalid beat is drained, not stalled.
//     Otherwise -> &(~tm | free). All targets must be free; no partial broadcast.
//     in_ready has a combinational path from out_ready and mode/in_sel; it does not
//     depend on in_valid.
//   acc = in_valid & in_ready. On each clk edge, for every channel i:
//     acc & tm[i] -> out_valid[i]<=1, out_data_i<=in_data.
//     else if out_ready[i] -> out_valid[i]<=0 and data held.
//     else hold.
//   Latency: accepted beat is visible on out_* in the next cycle.
//     out_data_i is stable while out_valid[i] & ~out_ready[i].
//   rr_ptr: on acc in RR mode, advance by 1, wrapping N_CH-1 -> 0. Otherwise hold.
//   err <= acc & (tm==0). Otherwise err <= 0. Dropped beats change no slot and no rr_ptr.
//   Mode or in_sel may change on any cycle. Only the current cycle's values route.
//     Beats already in slots are unaffected.
//   Reset mid-operation discards all slot contents. No beat is presented after
//     rst falls until a new accept.
// STRUCTURE
//   Package stream_demux_pkg: mode constants MODE_SEL=2'b00, MODE_BCAST=2'b01,
//     MODE_RR=2'b10, MODE_RSVD=2'b11.
//   Sub-module demux_out_slot (DATA_W), instantiated N_CH times in a generate loop.
//     Inputs: load, in_data, out_ready. Outputs: out_valid, out_data, free.
//   Top holds the target-mask decode, in_ready reduction, rr_ptr counter and err register.
// TESTING
//   1. SEL, N_CH=4: send 0xA5 with sel=2, all ready -> next cycle out_valid=4'b0100,
//      ch2 data 0xA5; in_ready stays 1 throughout.
//   2. Backpressure: sel=1, out_ready[1]=0, send 0x11 then 0x22 -> 0x11 held on ch1,
//      in_ready=0 for 2nd beat. Raise out_ready[1] -> 0x22 loaded the same cycle.
//   3. BCAST: out_ready=4'b1011, slot 2 full, send 0x3C -> in_ready=0, no slot written.
//      Free slot 2 -> all 4 channels show 0x3C together.
//   4. RR: 6 beats 0..5 with all ready -> channel order 0,1,2,3,0,1; rr_ptr ends at 2.
//      Rerun with N_CH=3 -> order 0,1,2,0,1,2 and rr_ptr ends at 0.
//   5. Error: N_CH=3, sel=3 -> in_ready=1, err pulses once, out_valid unchanged.
//      mode=11 -> same response.
//   6. Reset: assert rst asynchronously while out_valid=4'b1111, between edges ->
//      out_valid=0 immediately, rr_ptr=0. First post-reset beat routes normally.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// Shared routing-mode encoding for the stream demultiplexer and its users.
package stream_demux_pkg;

  typedef enum logic [1:0] {
    MODE_SEL   = 2'b00,
    MODE_BCAST = 2'b01,
    MODE_RR    = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry output register for a demux channel; loaded beat appears next cycle.
// Reports free when empty or draining, so a slot refills in the same cycle it empties.
module demux_out_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              free
);

  assign free = ~out_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_demux.sv
// 1-to-N demux (select / broadcast / round-robin); one cycle to registered outputs.
// Producer is stalled until every targeted slot is free; beats with no target are dropped.
module stream_demux
  import stream_demux_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int DATA_W = 8,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_data,
  input  logic [SEL_W-1:0]       in_sel,
  output logic [N_CH-1:0]        out_valid,
  input  logic [N_CH-1:0]        out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]       rr_ptr,
  output logic                   err
);

  logic [N_CH-1:0] tm;
  logic [N_CH-1:0] free;
  logic [N_CH-1:0] load;
  logic            acc;
  logic            no_target;

  // Index compare per channel leaves the mask empty for in_sel >= N_CH.
  always_comb begin
    tm = '0;
    for (int i = 0; i < N_CH; i++) begin
      case (mode)
        MODE_SEL:   tm[i] = (int'(in_sel) == i);
        MODE_BCAST: tm[i] = 1'b1;
        MODE_RR:    tm[i] = (int'(rr_ptr) == i);
        default:    tm[i] = 1'b0;
      endcase
    end
  end

  assign no_target = (tm == '0);
  assign in_ready  = no_target | (&(~tm | free));
  assign acc       = in_valid & in_ready;
  assign load      = {N_CH{acc}} & tm;

  for (genvar i = 0; i < N_CH; i++) begin : g_slot
    demux_out_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk      (clk),
      .rst      (rst),
      .load     (load[i]),
      .in_data  (in_data),
      .out_ready(out_ready[i]),
      .out_valid(out_valid[i]),
      .out_data (out_data[i*DATA_W +: DATA_W]),
      .free     (free[i])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      err    <= 1'b0;
    end else begin
      err <= acc & no_target;
      if (acc && (mode == MODE_RR)) begin
        rr_ptr <= (int'(rr_ptr) == N_CH - 1) ? '0 : rr_ptr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux with 4- and 3-channel instances sharing clock and reset.
module tb_stream_demux;
  import stream_demux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]  mode4 = 2'b00, sel4 = 2'b00, rr_ptr4;
  logic        valid4 = 1'b0, in_ready4, err4;
  logic [7:0]  data4 = 8'h00;
  logic [3:0]  out_valid4, ordy4 = 4'hF;
  logic [31:0] out_data4;

  logic [1:0]  mode3 = 2'b00, sel3 = 2'b00, rr_ptr3;
  logic        valid3 = 1'b0, in_ready3, err3;
  logic [7:0]  data3 = 8'h00;
  logic [2:0]  out_valid3, ordy3 = 3'h7;
  logic [23:0] out_data3;

  stream_demux #(.N_CH(4), .DATA_W(8)) dut4 (
    .clk(clk), .rst(rst), .mode(mode4), .in_valid(valid4), .in_ready(in_ready4),
    .in_data(data4), .in_sel(sel4), .out_valid(out_valid4), .out_ready(ordy4),
    .out_data(out_data4), .rr_ptr(rr_ptr4), .err(err4));

  stream_demux #(.N_CH(3), .DATA_W(8)) dut3 (
    .clk(clk), .rst(rst), .mode(mode3), .in_valid(valid3), .in_ready(in_ready3),
    .in_data(data3), .in_sel(sel3), .out_valid(out_valid3), .out_ready(ordy3),
    .out_data(out_data3), .rr_ptr(rr_ptr3), .err(err3));

  int n_pass = 0;
  int n_total = 0;
  logic [7:0] q4 [4][$];
  logic [7:0] q3 [3][$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // Monitors: compare every presented beat with the channel's queue head, pop on handshake.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid4[i]) begin
          if (q4[i].size() == 0) begin
            n_total++;
            $display("FAIL d4 ch%0d unexpected beat: got %0h, expected none", i, out_data4[i*8 +: 8]);
          end else begin
            chk($sformatf("d4 ch%0d data", i), {24'd0, out_data4[i*8 +: 8]}, {24'd0, q4[i][0]});
            if (ordy4[i]) void'(q4[i].pop_front());
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        if (out_valid3[i]) begin
          if (q3[i].size() == 0) begin
            n_total++;
            $display("FAIL d3 ch%0d unexpected beat: got %0h, expected none", i, out_data3[i*8 +: 8]);
          end else begin
            chk($sformatf("d3 ch%0d data", i), {24'd0, out_data3[i*8 +: 8]}, {24'd0, q3[i][0]});
            if (ordy3[i]) void'(q3[i].pop_front());
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    valid4 = 1'b0;
    valid3 = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  // Present one beat for one cycle; exp_rdy/mask are the hand-derived expectations.
  task automatic drive4(input logic [1:0] m, input logic [1:0] s, input logic [7:0] d,
                        input logic exp_rdy, input logic [3:0] mask);
    mode4 = m; sel4 = s; data4 = d; valid4 = 1'b1;
    @(negedge clk);
    chk("d4 in_ready", {31'd0, in_ready4}, {31'd0, exp_rdy});
    if (exp_rdy) for (int i = 0; i < 4; i++) if (mask[i]) q4[i].push_back(d);
    tick();
    if (exp_rdy && mask != 4'd0) chk("d4 load", {28'd0, out_valid4 & mask}, {28'd0, mask});
    valid4 = 1'b0;
  endtask

  task automatic drive3(input logic [1:0] m, input logic [1:0] s, input logic [7:0] d,
                        input logic exp_rdy, input logic [2:0] mask);
    mode3 = m; sel3 = s; data3 = d; valid3 = 1'b1;
    @(negedge clk);
    chk("d3 in_ready", {31'd0, in_ready3}, {31'd0, exp_rdy});
    if (exp_rdy) for (int i = 0; i < 3; i++) if (mask[i]) q3[i].push_back(d);
    tick();
    if (exp_rdy && mask != 3'd0) chk("d3 load", {29'd0, out_valid3 & mask}, {29'd0, mask});
    valid3 = 1'b0;
  endtask

  initial begin
    int ch4 [6];
    logic [2:0] held;
    ch4 = '{0, 1, 2, 3, 0, 1};

    // Reset state
    #2;
    chk("rst out_valid4", {28'd0, out_valid4}, 32'd0);
    chk("rst out_data4", out_data4, 32'd0);
    chk("rst rr_ptr4", {30'd0, rr_ptr4}, 32'd0);
    chk("rst err4", {31'd0, err4}, 32'd0);
    chk("rst out_valid3", {29'd0, out_valid3}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Select mode, all consumers ready
    ordy4 = 4'hF;
    drive4(MODE_SEL, 2'd2, 8'hA5, 1'b1, 4'b0100);
    chk("sel out_valid4", {28'd0, out_valid4}, 32'h4);
    chk("sel ch2 data", {24'd0, out_data4[23:16]}, 32'hA5);
    chk("sel in_ready after", {31'd0, in_ready4}, 32'd1);
    idle(2);

    // Backpressure on channel 1
    ordy4 = 4'b1101;
    drive4(MODE_SEL, 2'd1, 8'h11, 1'b1, 4'b0010);
    drive4(MODE_SEL, 2'd1, 8'h22, 1'b0, 4'b0010);
    drive4(MODE_SEL, 2'd1, 8'h22, 1'b0, 4'b0010);
    chk("bp ch1 held", {24'd0, out_data4[15:8]}, 32'h11);
    ordy4 = 4'b1111;
    drive4(MODE_SEL, 2'd1, 8'h22, 1'b1, 4'b0010);
    chk("bp ch1 refill", {24'd0, out_data4[15:8]}, 32'h22);
    idle(2);

    // Broadcast blocked by one full slot, then released
    ordy4 = 4'b1011;
    drive4(MODE_SEL, 2'd2, 8'h77, 1'b1, 4'b0100);
    drive4(MODE_BCAST, 2'd0, 8'h3C, 1'b0, 4'b1111);
    chk("bcast blocked valid", {28'd0, out_valid4}, 32'h4);
    chk("bcast blocked ch0", {24'd0, out_data4[7:0]}, 32'h0);
    ordy4 = 4'b1111;
    drive4(MODE_BCAST, 2'd0, 8'h3C, 1'b1, 4'b1111);
    chk("bcast all data", out_data4, 32'h3C3C3C3C);

    // Round robin, 4 channels
    for (int k = 0; k < 6; k++) begin
      chk("d4 rr_ptr before", {30'd0, rr_ptr4}, ch4[k]);
      drive4(MODE_RR, 2'd0, k[7:0], 1'b1, 4'(1 << ch4[k]));
    end
    chk("d4 rr_ptr end", {30'd0, rr_ptr4}, 32'd2);
    idle(2);

    // Round robin, 3 channels
    for (int k = 0; k < 6; k++) begin
      drive3(MODE_RR, 2'd0, 8'h10 + k[7:0], 1'b1, 3'(1 << (k % 3)));
    end
    chk("d3 rr_ptr end", {30'd0, rr_ptr3}, 32'd0);
    idle(2);

    // Dropped beats: out-of-range select, then reserved mode
    ordy3 = 3'b011;
    drive3(MODE_SEL, 2'd2, 8'h42, 1'b1, 3'b100);
    held = out_valid3;
    drive3(MODE_SEL, 2'd3, 8'h99, 1'b1, 3'b000);
    chk("bad sel err", {31'd0, err3}, 32'd1);
    chk("bad sel out_valid", {29'd0, out_valid3}, {29'd0, held});
    chk("bad sel ch2 data", {24'd0, out_data3[23:16]}, 32'h42);
    idle(1);
    chk("bad sel err clears", {31'd0, err3}, 32'd0);
    drive3(MODE_RSVD, 2'd0, 8'h98, 1'b1, 3'b000);
    chk("rsvd err", {31'd0, err3}, 32'd1);
    chk("rsvd out_valid", {29'd0, out_valid3}, {29'd0, held});
    chk("rsvd rr_ptr", {30'd0, rr_ptr3}, 32'd0);
    idle(1);
    chk("rsvd err clears", {31'd0, err3}, 32'd0);
    ordy3 = 3'b111;
    drive4(MODE_RSVD, 2'd0, 8'hEE, 1'b1, 4'b0000);
    chk("d4 rsvd err", {31'd0, err4}, 32'd1);
    idle(3);

    // Asynchronous reset with all four slots full
    ordy4 = 4'b0000;
    mode4 = MODE_RR;
    drive4(MODE_BCAST, 2'd0, 8'h55, 1'b1, 4'b1111);
    chk("pre-rst rr_ptr4", {30'd0, rr_ptr4}, 32'd2);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) q4[i].delete();
    for (int i = 0; i < 3; i++) q3[i].delete();
    #1;
    chk("async rst out_valid4", {28'd0, out_valid4}, 32'd0);
    chk("async rst rr_ptr4", {30'd0, rr_ptr4}, 32'd0);
    chk("async rst out_data4", out_data4, 32'd0);
    tick();
    rst = 1'b0;
    ordy4 = 4'hF;
    tick();
    chk("post-rst no beat", {28'd0, out_valid4}, 32'd0);
    drive4(MODE_SEL, 2'd3, 8'hC3, 1'b1, 4'b1000);
    chk("post-rst ch3 data", {24'd0, out_data4[31:24]}, 32'hC3);
    idle(3);

    for (int i = 0; i < 4; i++) chk($sformatf("d4 q%0d drained", i), q4[i].size(), 32'd0);
    for (int i = 0; i < 3; i++) chk($sformatf("d3 q%0d drained", i), q3[i].size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
